// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer: shift-add multiplier and restoring divider
// sharing one 33-bit adder, fixed 35-cycle start-to-done latency.
module muldiv_seq #(
    parameter int unsigned D_WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [2:0]         funct3_i,
    input  logic [D_WIDTH-1:0] op1_i,
    input  logic [D_WIDTH-1:0] op2_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [D_WIDTH-1:0] result_o
);

    localparam int unsigned W    = D_WIDTH;
    localparam int unsigned CntW = $clog2(D_WIDTH);

    localparam logic [W-1:0]    OneW     = {{(W-1){1'b0}}, 1'b1};
    localparam logic [2*W-1:0]  OneD     = {{(2*W-1){1'b0}}, 1'b1};
    localparam logic [W:0]      OneA     = {{W{1'b0}}, 1'b1};
    localparam logic [CntW-1:0] CntOne   = {{(CntW-1){1'b0}}, 1'b1};
    localparam logic [CntW-1:0] CntLast  = {CntW{1'b1}};

    localparam logic [2:0] F3Mul    = 3'b000;
    localparam logic [2:0] F3Mulh   = 3'b001;
    localparam logic [2:0] F3Mulhsu = 3'b010;
    localparam logic [2:0] F3Mulhu  = 3'b011;
    localparam logic [2:0] F3Div    = 3'b100;
    localparam logic [2:0] F3Divu   = 3'b101;
    localparam logic [2:0] F3Rem    = 3'b110;
    localparam logic [2:0] F3Remu   = 3'b111;

    typedef enum logic [2:0] {
        StIdle,
        StPrep,
        StCalc,
        StFix,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [2:0]      funct3_q, funct3_d;
    logic [W-1:0]    op1_q, op1_d;
    logic [W-1:0]    op2_q, op2_d;
    logic [W-1:0]    a_q, a_d;      // multiplier / dividend bits, shifted out one per cycle
    logic [W-1:0]    b_q, b_d;      // multiplicand / divisor magnitude
    logic [2*W-1:0]  acc_q, acc_d;  // {hi, lo} product or {rem, quo}
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            neg_q, neg_d;
    logic            divzero_q, divzero_d;
    logic [W-1:0]    result_q, result_d;

    // Operand decode, valid from PREP onward
    logic         is_div, is_rem, op1_signed, op2_signed, op1_neg, op2_neg;
    logic [W-1:0] op1_abs, op2_abs;

    always_comb begin
        is_div     = funct3_q[2];
        is_rem     = funct3_q[2] & funct3_q[1];
        op1_signed = (funct3_q == F3Mulh) || (funct3_q == F3Mulhsu) ||
                     (funct3_q == F3Div)  || (funct3_q == F3Rem);
        op2_signed = (funct3_q == F3Mulh) || (funct3_q == F3Div) || (funct3_q == F3Rem);
        op1_neg    = op1_signed & op1_q[W-1];
        op2_neg    = op2_signed & op2_q[W-1];
        op1_abs    = op1_neg ? (~op1_q + OneW) : op1_q;
        op2_abs    = op2_neg ? (~op2_q + OneW) : op2_q;
    end

    // Shared 33-bit adder: accumulate for multiply, trial-subtract for divide
    logic [W:0] rem_sh, add_a, add_b, add_sum;
    logic       add_cin;

    always_comb begin
        rem_sh = {acc_q[2*W-1:W], a_q[W-1]};
        if (is_div) begin
            add_a   = rem_sh;
            add_b   = ~{1'b0, b_q};
            add_cin = 1'b1;
        end else begin
            add_a   = {1'b0, acc_q[2*W-1:W]};
            add_b   = a_q[0] ? {1'b0, b_q} : '0;
            add_cin = 1'b0;
        end
        add_sum = add_a + add_b + (add_cin ? OneA : '0);
    end

    // Sign fix-up: products negate across all 64 bits so the high half
    // picks up the borrow from the low half; quotient/remainder negate alone.
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   half, half_fix, fix_val;

    always_comb begin
        prod_fix = neg_q ? (~acc_q + OneD) : acc_q;
        half     = is_rem ? acc_q[2*W-1:W] : acc_q[W-1:0];
        half_fix = neg_q ? (~half + OneW) : half;
        fix_val  = '0;
        unique case (funct3_q)
            F3Mul:                     fix_val = prod_fix[W-1:0];
            F3Mulh, F3Mulhsu, F3Mulhu: fix_val = prod_fix[2*W-1:W];
            F3Div, F3Divu:             fix_val = divzero_q ? '1 : half_fix;
            F3Rem, F3Remu:             fix_val = divzero_q ? op1_q : half_fix;
            default:                   fix_val = '0;
        endcase
    end

    logic [W-1:0] new_rem;

    always_comb begin
        state_d   = state_q;
        funct3_d  = funct3_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        divzero_d = divzero_q;
        result_d  = result_q;
        new_rem   = add_sum[W] ? rem_sh[W-1:0] : add_sum[W-1:0];

        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    funct3_d = funct3_i;
                    op1_d    = op1_i;
                    op2_d    = op2_i;
                    state_d  = StPrep;
                end else begin
                    state_d  = StIdle;
                end
            end
            StPrep: begin
                a_d       = op1_abs;
                b_d       = op2_abs;
                neg_d     = is_rem ? op1_neg : (op1_neg ^ op2_neg);
                divzero_d = is_div & (op2_q == '0);
                cnt_d     = '0;
                acc_d     = '0;
                state_d   = StCalc;
            end
            StCalc: begin
                if (is_div) begin
                    // Borrow out (add_sum[W]) means the trial went negative: restore
                    acc_d = {new_rem, acc_q[W-2:0], ~add_sum[W]};
                    a_d   = {a_q[W-2:0], 1'b0};
                end else begin
                    acc_d = {add_sum, acc_q[W-1:1]};
                    a_d   = {1'b0, a_q[W-1:1]};
                end
                if (cnt_q == CntLast) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StFix: begin
                result_d = fix_val;
                state_d  = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            funct3_q  <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            divzero_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            funct3_q  <= funct3_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            divzero_q <= divzero_d;
            result_q  <= result_d;
        end
    end

    assign busy_o   = (state_q == StPrep) || (state_q == StCalc) || (state_q == StFix);
    assign done_o   = (state_q == StDone);
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, busy/done framing, RV32M results and corner cases.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op1, op2;
    logic        busy, done;
    logic [31:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.D_WIDTH(32)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .funct3_i (funct3),
        .op1_i    (op1),
        .op2_i    (op2),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Independent RISC-V reference using 64-bit host arithmetic
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] sa, za, sb, zb, p;
        sa = {{32{a[31]}}, a};
        za = {32'b0, a};
        sb = {{32{b[31]}}, b};
        zb = {32'b0, b};
        case (f)
            3'd0: begin p = za * zb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * zb; return p[63:32]; end
            3'd3: begin p = za * zb; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    task automatic drive_start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        funct3 = f;
        op1    = a;
        op2    = b;
    endtask

    // Accepting edge; operands are scrambled right after to prove they were captured
    task automatic accept();
        @(posedge clk);
        #1;
        start  = 1'b0;
        funct3 = 3'($urandom);
        op1    = $urandom;
        op2    = $urandom;
    endtask

    task automatic collect(input string tag, input logic [31:0] exp, input bit poke,
                           input bit chain, input logic [2:0] cf, input logic [31:0] ca,
                           input logic [31:0] cb);
        int busy_cnt = 0;
        int done_at  = 0;
        int overlap  = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (busy && done) overlap++;
            if (done) begin
                done_at = k;
                check_eq({tag, "_result"}, result, exp);
                if (chain) drive_start(cf, ca, cb);
                else start = 1'b0;
                break;
            end
            if (poke && (k == 3 || k == 20 || k == 34)) begin
                start  = 1'b1;
                funct3 = 3'b000;
                op1    = 32'd1;
                op2    = 32'd1;
            end else begin
                start  = 1'b0;
            end
        end
        check_eq({tag, "_latency"}, 32'(done_at), 32'd35);
        check_eq({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd34);
        check_eq({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        drive_start(f, a, b);
        accept();
        collect(tag, exp, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    endtask

    initial begin
        int late_done;
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        // Reset with a coincident start: the start must be dropped
        rst    = 1'b1;
        start  = 1'b1;
        funct3 = 3'b000;
        op1    = 32'd5;
        op2    = 32'd5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check_eq("reset_busy", {31'b0, busy}, 32'd0);
        check_eq("reset_done", {31'b0, done}, 32'd0);
        check_eq("reset_result", result, 32'd0);
        @(negedge clk);
        check_eq("start_in_reset_dropped", {31'b0, busy}, 32'd0);

        // Multiply
        run_op("mul_7x6", 3'b000, 32'd7, 32'd6, 32'd42);
        run_op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulh_m1x2", 3'b001, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        run_op("mulhsu_min", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);

        // Divide
        run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14);
        run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2);

        // Corners
        run_op("divu_by0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op("rem_by0", 3'b110, 32'd5, 32'd0, 32'd5);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Result held after done
        repeat (3) @(negedge clk);
        check_eq("hold_result", result, 32'd0);
        check_eq("hold_done_low", {31'b0, done}, 32'd0);
        run_op("rem_m9_4", 3'b110, 32'hFFFF_FFF7, 32'd4, 32'hFFFF_FFFF);
        repeat (4) @(negedge clk);
        check_eq("hold_result2", result, 32'hFFFF_FFFF);

        // Starts while busy are ignored; a start in DONE is accepted
        drive_start(3'b000, 32'd12, 32'd11);
        accept();
        collect("ignore_start", 32'd132, 1'b1, 1'b1, 3'b101, 32'd100, 32'd7);
        accept();
        collect("b2b_divu", 32'd14, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);

        // Reset in cycle 20 of an operation
        drive_start(3'b000, 32'd3, 32'd5);
        accept();
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_busy", {31'b0, busy}, 32'd0);
        check_eq("midrst_done", {31'b0, done}, 32'd0);
        check_eq("midrst_result", result, 32'd0);
        rst = 1'b0;
        late_done = 0;
        repeat (45) begin
            @(negedge clk);
            if (done || busy) late_done++;
        end
        check_eq("midrst_no_late_activity", 32'(late_done), 32'd0);
        run_op("mul_3x3", 3'b000, 32'd3, 32'd3, 32'd9);

        // Small randomized sweep against the reference model
        for (int i = 0; i < 16; i++) begin
            rf = 3'(i);
            ra = $urandom;
            rb = (i >= 8) ? 32'($urandom_range(0, 9)) : $urandom;
            if (i == 13) rb = 32'd0;
            run_op($sformatf("rnd%0d", i), rf, ra, rb, ref_op(rf, ra, rb));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for the RV32M multiply/divide instructions, alongside the single-cycle ALU in the execute stage. The decoder routes M-extension instructions here instead of to the ALU. The core holds PC and the instruction while `busy` is high, and writes `result` to the register file in the cycle `done` pulses. The block owns a 33-bit add/subtract unit, a shift-add multiplier datapath and a restoring divider datapath, all controlled by a single FSM.

## Interface
- `D_WIDTH`, 32: operand/result width. Only 32 is supported. The iteration counter width is `$clog2(D_WIDTH)`.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request. Sampled only when the state is IDLE or DONE.
- `funct3` in 3: RV32M op. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op1` in D_WIDTH: rs1 value. Captured on an accepted start.
- `op2` in D_WIDTH: rs2 value. Captured on an accepted start.
- `busy` out 1: operation in progress; the core stalls while this is high.
- `done` out 1: one-cycle pulse; `result` is valid in this cycle.
- `result` out D_WIDTH: final value. Held stable from `done` until the next accepted start.

## Operation
- **FSM states:** IDLE → PREP → CALC → FIX → DONE → IDLE.
- **IDLE / DONE:** `start`=1 captures `funct3`, `op1`, `op2` and moves to PREP. A start in the DONE cycle is accepted, so back-to-back operations are allowed. `start` in any other state is ignored.
- **PREP:**
  - Computes operand signedness:
    - MULH: both operands signed.
    - MULHSU: op1 signed only.
    - DIV, REM: both operands signed.
    - All others: unsigned.
  - Stores the magnitudes |op1| and |op2| and the sign flags.
  - Result sign:
    - Multiply and quotient: sign(op1) XOR sign(op2).
    - Remainder: sign(op1).
  - Flags `divzero` (divide op and op2 == 0). The latency is unchanged by this flag.
  - Clears the counter and the 64-bit accumulator/remainder register.
- **CALC:** exactly D_WIDTH iterations, one per cycle, counter counting 0..31.
  - Multiply: if the multiplier LSB is 1, add the multiplicand to the accumulator high half through the 33-bit adder. Then shift {carry, acc} right by 1.
  - Divide: shift {rem, quo} left by 1 and trial-subtract the divisor through the 33-bit adder. If the result is non-negative, keep it and set the quotient LSB; otherwise restore.
- **FIX:**
  - Negate the selected half (two's complement) if the result sign is 1 and the op is signed.
  - Selection: MUL → low 32 bits; MULH/MULHSU/MULHU → high 32 bits; DIV/DIVU → quotient; REM/REMU → remainder.
  - Divide-by-zero override: DIV/DIVU → 0xFFFFFFFF; REM/REMU → op1 unmodified.
  - Signed overflow (op1 = 0x80000000, op2 = 0xFFFFFFFF): DIV → 0x80000000, REM → 0. The algorithm produces these values without special-casing, and they must hold.
  - Registers `result`.
- **DONE:** `done`=1 and `busy`=0. Returns to IDLE unless a new start is accepted.

## Timing
- **Reset:**
  - `rst`=1 forces IDLE on the next edge, from any state, including mid-CALC.
  - Output values after reset: `busy`=0, `done`=0, `result`=0; counter and internal registers cleared.
  - A `start` coincident with `rst` is dropped.
- **Fixed latency:** start sampled at edge 0.
  - PREP: cycle 1.
  - CALC: cycles 2–33.
  - FIX: cycle 34.
  - DONE: cycle 35, with `done`=1.
- **busy:** high exactly in cycles 1–34. This is 34 cycles, registered, with no combinational path from `start`.
- **done:** high only in cycle 35. It never coincides with `busy`.
- **Operand capture:** `op1`, `op2` and `funct3` may change after the accepting edge without affecting the result.
- **Counter:** ends CALC at count 31 with no wrap into a 33rd iteration.

## Test plan
- **Basic multiply:** MUL 7 × 6 → `result`=42, with `done` exactly 35 cycles after start and `busy` high for 34 cycles. Then MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. Then MULH 0xFFFFFFFF (−1) × 2 → 0xFFFFFFFF.
- **Basic divide:** DIV −7 / 2 → 0xFFFFFFFD (−3). REM −7 / 2 → 0xFFFFFFFF (−1). DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- **Corner cases:** DIVU 5 / 0 → 0xFFFFFFFF. REM 5 / 0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM of the same operands → 0. All with 35-cycle latency.
- **Start handling:** start pulses during cycles 1–34 are ignored and the result is unchanged. A start asserted in the DONE cycle is accepted, and its `done` follows 35 cycles later.
- **Reset mid-operation:** `rst` in cycle 20 → `busy`=0, `done`=0, `result`=0 the next cycle; no `done` pulse appears later. A fresh MUL 3 × 3 then returns 9.
- **Randomized check:** 10k random `funct3`/`op1`/`op2` triples checked against a reference model of the RISC-V spec. `result` must be held stable between `done` and the next start.
